aiken_bcd_display: RTL

- Downstream consumer of the 2421 (Aiken) decade counter.
- Samples the counter's 4-bit 2421 code and validates it, then converts it to a BCD ones digit.
- Detects decade roll-over (9→0) to run a BCD tens digit.
- Drives a time-multiplexed 2-digit active-low 7-segment display; illegal 2421 codes raise a sticky error shown as "EE".

---
 rtl/aiken_bcd_display.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/aiken_bcd_display.sv
// Validates 2421 (Aiken) samples from a decade counter, keeps a two-digit BCD count,
// and time-multiplexes it onto an active-low 7-segment display ("EE" on an illegal code).
module aiken_bcd_display #(
  parameter int SCAN_DIV = 50000,
  parameter int CW       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] code_in,
  input  logic       clr,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       carry_out,
  output logic       code_err,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  // Returns {legal, bcd}; the 2421 codes 0101..1010 are unused by the counter.
  function automatic logic [4:0] decode_2421(input logic [3:0] code);
    logic [4:0] res;
    case (code)
      4'b0000: res = {1'b1, 4'd0};
      4'b0001: res = {1'b1, 4'd1};
      4'b0010: res = {1'b1, 4'd2};
      4'b0011: res = {1'b1, 4'd3};
      4'b0100: res = {1'b1, 4'd4};
      4'b1011: res = {1'b1, 4'd5};
      4'b1100: res = {1'b1, 4'd6};
      4'b1101: res = {1'b1, 4'd7};
      4'b1110: res = {1'b1, 4'd8};
      4'b1111: res = {1'b1, 4'd9};
      default: res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h06;
    endcase
    return pat;
  endfunction

  logic [3:0]    r_ones;
  logic [3:0]    r_tens;
  logic          r_carry;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic          r_sel;

  logic [4:0]    w_dec;
  logic          w_legal;
  logic [3:0]    w_digit;
  logic          w_roll;
  logic [3:0]    w_shown;

  // Decode the incoming sample and detect a 9 -> 0 roll-over of the ones digit.
  always_comb begin
    w_dec   = decode_2421(code_in);
    w_legal = w_dec[4];
    w_digit = w_dec[3:0];
    w_roll  = 1'b0;
    if (in_valid && w_legal && (r_ones == 4'd9) && (w_digit == 4'd0)) begin
      w_roll = 1'b1;
    end else begin
      w_roll = 1'b0;
    end
  end

  // Digit, carry and sticky error state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ones  <= 4'd0;
      r_tens  <= 4'd0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else if (clr) begin
      r_ones  <= 4'd0;
      r_tens  <= 4'd0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_carry <= w_roll;
      if (in_valid) begin
        if (w_legal) begin
          r_ones <= w_digit;
          if (w_roll) begin
            r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
          end
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Scan divider: sel flips each time the counter wraps from SCAN_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
    end else if (r_cnt == SCAN_LAST) begin
      r_cnt <= '0;
      r_sel <= ~r_sel;
    end else begin
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Display drive from registered state only.
  always_comb begin
    w_shown = r_ones;
    an      = 2'b10;
    seg     = 7'h40;
    if (r_sel) begin
      w_shown = r_tens;
      an      = 2'b01;
    end else begin
      w_shown = r_ones;
      an      = 2'b10;
    end
    if (r_err) begin
      seg = 7'h06;
    end else begin
      seg = seg_of(w_shown);
    end
  end

  assign bcd_ones  = r_ones;
  assign bcd_tens  = r_tens;
  assign carry_out = r_carry;
  assign code_err  = r_err;

endmodule
